// File: rtl/sar_logic_tscs.sv
// Two-step (coarse/fine) successive-approximation controller.
// Sequences sampling, MSB-first bit trials and end-of-conversion, and drives
// the DAC trial word, comparator strobe and the split-array switch controls.
// Every output comes straight from a flop; next values are built in one
// combinational process and captured on the rising edge.

module sar_logic_tscs #(
    parameter int NBITS         = 10,
    parameter int NFINE         = 5,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cnvst_i,
    input  logic             cont_i,
    input  logic             cmp_out_i,
    output logic [NBITS-1:0] sar_o,
    output logic [NBITS-1:0] dout_o,
    output logic             eoc_o,
    output logic             busy_o,
    output logic             cmp_clk_o,
    output logic             s_clk_o,
    output logic             s_clk_not_o,
    output logic             fine_switch_S_o,
    output logic             fine_switch_S_not_o
);

    localparam int IW = $clog2(NBITS);
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    localparam logic [IW-1:0] IDX_MSB  = IW'(NBITS - 1);
    localparam logic [IW-1:0] IDX_FINE = IW'(NFINE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SET    = 3'd2,
        ST_COMP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] sar_q, sar_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             eoc_q, eoc_d;
    logic             busy_q, busy_d;
    logic             cmp_clk_q, cmp_clk_d;
    logic             s_clk_q, s_clk_d;
    logic             s_clk_not_q;
    logic             fine_q, fine_d;
    logic             fine_not_q;
    logic [IW-1:0]    idx_dec_s;

    // Next-state and next-output logic; strobes default low, words hold.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        sar_d     = sar_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        eoc_d     = 1'b0;
        cmp_clk_d = 1'b0;
        s_clk_d   = 1'b0;
        fine_d    = 1'b0;
        idx_dec_s = idx_q - IW'(1);

        case (state_q)
            ST_IDLE: begin
                if (cnvst_i) begin
                    state_d = ST_SAMPLE;
                    sar_d   = '0;
                    busy_d  = 1'b1;
                    s_clk_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    // Sampling switch opens on the same edge the MSB trial starts.
                    state_d        = ST_SET;
                    idx_d          = IDX_MSB;
                    sar_d[IDX_MSB] = 1'b1;
                    fine_d         = (IDX_MSB < IDX_FINE);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    s_clk_d = 1'b1;
                end
            end

            ST_SET: begin
                state_d   = ST_COMP;
                cmp_clk_d = 1'b1;
                fine_d    = (idx_q < IDX_FINE);
            end

            ST_COMP: begin
                // Keep the trial bit only if Vin >= DAC.
                sar_d[idx_q] = sar_q[idx_q] & cmp_out_i;
                if (idx_q != '0) begin
                    state_d          = ST_SET;
                    idx_d            = idx_dec_s;
                    sar_d[idx_dec_s] = 1'b1;
                    fine_d           = (idx_dec_s < IDX_FINE);
                end else begin
                    state_d = ST_DONE;
                    dout_d  = sar_d;
                    eoc_d   = 1'b1;
                end
            end

            ST_DONE: begin
                if (cont_i && cnvst_i) begin
                    state_d = ST_SAMPLE;
                    sar_d   = '0;
                    s_clk_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idx_d   = IDX_MSB;
            end
        endcase
    end

    // State and output registers; complements track their true outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_MSB;
            cnt_q       <= '0;
            sar_q       <= '0;
            dout_q      <= '0;
            eoc_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmp_clk_q   <= 1'b0;
            s_clk_q     <= 1'b0;
            s_clk_not_q <= 1'b1;
            fine_q      <= 1'b0;
            fine_not_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sar_q       <= sar_d;
            dout_q      <= dout_d;
            eoc_q       <= eoc_d;
            busy_q      <= busy_d;
            cmp_clk_q   <= cmp_clk_d;
            s_clk_q     <= s_clk_d;
            s_clk_not_q <= ~s_clk_d;
            fine_q      <= fine_d;
            fine_not_q  <= ~fine_d;
        end
    end

    assign sar_o               = sar_q;
    assign dout_o              = dout_q;
    assign eoc_o               = eoc_q;
    assign busy_o              = busy_q;
    assign cmp_clk_o           = cmp_clk_q;
    assign s_clk_o             = s_clk_q;
    assign s_clk_not_o         = s_clk_not_q;
    assign fine_switch_S_o     = fine_q;
    assign fine_switch_S_not_o = fine_not_q;

endmodule

// File: tb/tb_sar_logic_tscs.sv
// Bench for sar_logic_tscs: a default instance (10/5/2) and a 12/4/3 instance.
// The reference model tracks the cycle number within a conversion and the
// analog input value; expected outputs follow from the binary-search rule.

module tb_sar_logic_tscs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, cnvst_a, cont_a, cmp_a;
    logic [9:0]  sar_a, dout_a;
    logic        eoc_a, busy_a, cmpclk_a, sclk_a, sclkn_a, fine_a, finen_a;

    logic        rst_b, cnvst_b, cont_b, cmp_b;
    logic [11:0] sar_b, dout_b;
    logic        eoc_b, busy_b, cmpclk_b, sclk_b, sclkn_b, fine_b, finen_b;

    sar_logic_tscs #(.NBITS(10), .NFINE(5), .SAMPLE_CYCLES(2)) u_a (
        .clk_i(clk), .rst_i(rst_a), .cnvst_i(cnvst_a), .cont_i(cont_a),
        .cmp_out_i(cmp_a), .sar_o(sar_a), .dout_o(dout_a), .eoc_o(eoc_a),
        .busy_o(busy_a), .cmp_clk_o(cmpclk_a), .s_clk_o(sclk_a),
        .s_clk_not_o(sclkn_a), .fine_switch_S_o(fine_a),
        .fine_switch_S_not_o(finen_a)
    );

    sar_logic_tscs #(.NBITS(12), .NFINE(4), .SAMPLE_CYCLES(3)) u_b (
        .clk_i(clk), .rst_i(rst_b), .cnvst_i(cnvst_b), .cont_i(cont_b),
        .cmp_out_i(cmp_b), .sar_o(sar_b), .dout_o(dout_b), .eoc_o(eoc_b),
        .busy_o(busy_b), .cmp_clk_o(cmpclk_b), .s_clk_o(sclk_b),
        .s_clk_not_o(sclkn_b), .fine_switch_S_o(fine_b),
        .fine_switch_S_not_o(finen_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int p_n[2] = '{10, 12};
    int p_f[2] = '{5, 4};
    int p_s[2] = '{2, 3};

    // Model state: cycle within conversion (0 = idle), analog input, held code.
    int m_t[2]     = '{0, 0};
    int m_vin[2]   = '{0, 0};
    int m_hold[2]  = '{0, 0};
    int m_dout[2]  = '{0, 0};
    int m_force[2] = '{-1, -1};

    function automatic logic [31:0] expect_vec(int u);
        int n, f, s, t, off, k, e_sar;
        logic eoc, busy, cmpc, sc, fine;
        n = p_n[u]; f = p_f[u]; s = p_s[u]; t = m_t[u];
        eoc = 1'b0; busy = 1'b0; cmpc = 1'b0; sc = 1'b0; fine = 1'b0;
        e_sar = m_hold[u];
        if (t == 0) begin
            e_sar = m_hold[u];
        end else if (t <= s) begin
            e_sar = 0; busy = 1'b1; sc = 1'b1;
        end else if (t <= s + 2 * n) begin
            off   = t - s - 1;
            k     = n - 1 - off / 2;
            e_sar = ((m_vin[u] >> (k + 1)) << (k + 1)) | (1 << k);
            cmpc  = (off % 2) == 1;
            fine  = k < f;
            busy  = 1'b1;
        end else begin
            e_sar = m_vin[u]; eoc = 1'b1; busy = 1'b1;
        end
        return {1'b0, 12'(e_sar), 12'(m_dout[u]), eoc, busy, cmpc, sc, ~sc, fine, ~fine};
    endfunction

    function automatic logic [31:0] obs_vec(int u);
        if (u == 0)
            return {1'b0, 2'b00, sar_a, 2'b00, dout_a, eoc_a, busy_a, cmpclk_a,
                    sclk_a, sclkn_a, fine_a, finen_a};
        else
            return {1'b0, sar_b, dout_b, eoc_b, busy_b, cmpclk_b,
                    sclk_b, sclkn_b, fine_b, finen_b};
    endfunction

    task automatic model_update(int u, logic cnvst, logic cont, logic rst);
        int tl;
        tl = p_s[u] + 2 * p_n[u] + 1;
        if (rst) begin
            m_t[u] = 0; m_hold[u] = 0; m_dout[u] = 0;
        end else if (m_t[u] == 0 || m_t[u] == tl) begin
            if (cnvst && (m_t[u] == 0 || cont)) begin
                m_t[u]   = 1;
                m_vin[u] = (m_force[u] >= 0) ? m_force[u]
                                             : int'($urandom_range(0, (1 << p_n[u]) - 1));
            end else begin
                m_t[u] = 0;
            end
        end else begin
            m_t[u] = m_t[u] + 1;
            if (m_t[u] == tl) begin
                m_dout[u] = m_vin[u];
                m_hold[u] = m_vin[u];
            end
        end
    endtask

    task automatic step(string tag);
        logic [31:0] obs, exp;
        @(posedge clk);
        model_update(0, cnvst_a, cont_a, rst_a);
        model_update(1, cnvst_b, cont_b, rst_b);
        @(negedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) begin
            obs = obs_vec(u);
            exp = expect_vec(u);
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s unit %0d cyc %0d t %0d observed %h expected %h",
                       tag, u, cyc, m_t[u], obs, exp);
            end
        end
        cmp_a = (m_vin[0] >= int'(sar_a));
        cmp_b = (m_vin[1] >= int'(sar_b));
    endtask

    task automatic conv_a(int force_v, int ncyc, string tag);
        m_force[0] = force_v;
        cnvst_a = 1'b1;
        step(tag);
        cnvst_a = 1'b0;
        repeat (ncyc) step(tag);
    endtask

    initial begin
        rst_a = 1'b1; cnvst_a = 1'b0; cont_a = 1'b0; cmp_a = 1'b0;
        rst_b = 1'b1; cnvst_b = 1'b0; cont_b = 1'b0; cmp_b = 1'b0;
        @(negedge clk);
        repeat (3) step("reset");
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) step("idle");

        conv_a(10'h3FF, 25, "ones");
        conv_a(10'h000, 25, "zeros");
        conv_a(10'h2A5, 25, "code2a5");

        // Random codes with cnvst wiggling during the conversion.
        for (int r = 0; r < 6; r++) begin
            m_force[0] = -1;
            cnvst_a = 1'b1;
            step("rand_start");
            for (int c = 0; c < 22; c++) begin
                cnvst_a = 1'($urandom_range(0, 1));
                step("rand");
            end
            cnvst_a = 1'b0;
            repeat (26) step("rand_drain");
        end

        // Continuous back-to-back conversions, then fall back to per-request.
        m_force[0] = -1;
        cont_a = 1'b1; cnvst_a = 1'b1;
        repeat (70) step("cont");
        cont_a = 1'b0;
        repeat (50) step("cont_off");
        cnvst_a = 1'b0;
        repeat (26) step("cont_drain");

        // Reset in cycle 10 of a conversion, then a clean conversion.
        m_force[0] = 10'h155;
        cnvst_a = 1'b1;
        step("rst_mid");
        cnvst_a = 1'b0;
        repeat (9) step("rst_mid");
        rst_a = 1'b1;
        step("rst_mid_hit");
        rst_a = 1'b0;
        repeat (3) step("rst_after");
        conv_a(10'h2A5, 25, "post_rst");

        // Wider instance: all ones, then random codes.
        m_force[1] = 12'hFFF;
        cnvst_b = 1'b1;
        step("b_ones");
        cnvst_b = 1'b0;
        repeat (30) step("b_ones");
        m_force[1] = -1;
        for (int r = 0; r < 4; r++) begin
            cnvst_b = 1'b1;
            step("b_rand");
            cnvst_b = 1'b0;
            repeat (30) step("b_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
